// File: rtl/lp_filter_pkg.sv
// Shared definitions for the lp_filter sampler: FSM state encoding and a
// constant-width helper.
package lp_filter_pkg;

   typedef enum logic [0:0] {
      ST_SETTLE = 1'b0,
      ST_RUN    = 1'b1
   } state_t;

   // Smallest r with 2**r >= value; evaluated at elaboration for widths.
   function automatic int clog2(input int value);
      int result;
      result = 32'sd0;
      for (int i = 32'sd0; i < 32'sd31; i++) begin
         if ((32'sd1 << i) < value) begin
            result = i + 32'sd1;
         end else begin
            result = result;
         end
      end
      return result;
   endfunction

endpackage

// File: rtl/lp_filter_sampler_if.sv
// Consumer-side bus of the sampler: FWFT sample stream plus occupancy and
// drop status.
interface lp_filter_sampler_if #(
   parameter int DATA_BITS  = 28,
   parameter int FIFO_DEPTH = 8,
   parameter int DROP_BITS  = 8
);
   import lp_filter_pkg::*;

   localparam int LEVEL_BITS = clog2(FIFO_DEPTH) + 32'sd1;

   logic [DATA_BITS-1:0]  OUT_VALUE;
   logic                  OUT_VALID;
   logic                  OUT_READY;
   logic [LEVEL_BITS-1:0] FIFO_LEVEL;
   logic [DROP_BITS-1:0]  DROP_COUNT;

   modport master (
      output OUT_VALUE,
      output OUT_VALID,
      output FIFO_LEVEL,
      output DROP_COUNT,
      input  OUT_READY
   );

   modport slave (
      input  OUT_VALUE,
      input  OUT_VALID,
      input  FIFO_LEVEL,
      input  DROP_COUNT,
      output OUT_READY
   );

endinterface

// File: rtl/sample_fifo.sv
// Synchronous first-word-fall-through FIFO with a registered head word and
// registered full/empty/level flags.
module sample_fifo
   import lp_filter_pkg::*;
#(
   parameter int DATA_BITS  = 28,
   parameter int FIFO_DEPTH = 8,
   parameter int PTR_BITS   = clog2(FIFO_DEPTH),
   parameter int LEVEL_BITS = clog2(FIFO_DEPTH) + 32'sd1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  push,
   input  logic [DATA_BITS-1:0]  push_data,
   input  logic                  pop,
   output logic [DATA_BITS-1:0]  head_data,
   output logic                  full,
   output logic                  empty,
   output logic [LEVEL_BITS-1:0] level
);

   logic [DATA_BITS-1:0]  mem_q [FIFO_DEPTH];
   logic [DATA_BITS-1:0]  mem_d [FIFO_DEPTH];
   logic [PTR_BITS-1:0]   rd_ptr_q, rd_ptr_d;
   logic [PTR_BITS-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PTR_BITS-1:0]   rd_next_s;
   logic [LEVEL_BITS-1:0] level_q, level_d;
   logic [DATA_BITS-1:0]  head_q, head_d;
   logic                  full_q, full_d;
   logic                  empty_q, empty_d;
   logic                  do_pop_s, do_push_s;

   // A full FIFO still accepts a push when the head leaves in the same cycle.
   assign do_pop_s  = pop & ~empty_q;
   assign do_push_s = push & (~full_q | do_pop_s);
   assign rd_next_s = rd_ptr_q + PTR_BITS'(1);

   // Next-state for storage, pointers, occupancy and the registered head word.
   always_comb begin
      mem_d    = mem_q;
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      level_d  = level_q;
      head_d   = head_q;

      if (do_push_s) begin
         mem_d[wr_ptr_q] = push_data;
         wr_ptr_d        = wr_ptr_q + PTR_BITS'(1);
      end else begin
         wr_ptr_d = wr_ptr_q;
      end

      if (do_pop_s) begin
         rd_ptr_d = rd_next_s;
      end else begin
         rd_ptr_d = rd_ptr_q;
      end

      case ({do_push_s, do_pop_s})
         2'b10:   level_d = level_q + LEVEL_BITS'(1);
         2'b01:   level_d = level_q - LEVEL_BITS'(1);
         default: level_d = level_q;
      endcase

      // The head must be ready one edge ahead, so it bypasses storage when
      // the FIFO is (or is about to become) otherwise empty.
      if (level_d == {LEVEL_BITS{1'b0}}) begin
         head_d = {DATA_BITS{1'b0}};
      end else if (do_pop_s) begin
         if (level_q > LEVEL_BITS'(1)) begin
            head_d = mem_q[rd_next_s];
         end else begin
            head_d = push_data;
         end
      end else if (empty_q) begin
         head_d = push_data;
      end else begin
         head_d = head_q;
      end

      full_d  = (level_d == LEVEL_BITS'(FIFO_DEPTH));
      empty_d = (level_d == {LEVEL_BITS{1'b0}});
   end

   // Control state with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_ptr_q <= {PTR_BITS{1'b0}};
         wr_ptr_q <= {PTR_BITS{1'b0}};
         level_q  <= {LEVEL_BITS{1'b0}};
         head_q   <= {DATA_BITS{1'b0}};
         full_q   <= 1'b0;
         empty_q  <= 1'b1;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         level_q  <= level_d;
         head_q   <= head_d;
         full_q   <= full_d;
         empty_q  <= empty_d;
      end
   end

   // Sample storage needs no reset: entries are only read after being written.
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

   assign head_data = head_q;
   assign full      = full_q;
   assign empty     = empty_q;
   assign level     = level_q;

endmodule

// File: rtl/lp_filter_sampler.sv
// Decimating sampler on the lp_filter output feeding a FWFT sample FIFO.
// Optional feature macro: LP_FILTER_SAMPLER_DELTA_EN (store differences of captures).
module lp_filter_sampler
   import lp_filter_pkg::*;
#(
   parameter int DATA_BITS     = 28,
   parameter int DECIM         = 16,
   parameter int SETTLE_CYCLES = 256,
   parameter int FIFO_DEPTH    = 8,
   parameter int DROP_BITS     = 8
) (
   input  logic                 CLK,
   input  logic                 RESET,
   input  logic                 CE,
   input  logic [DATA_BITS-1:0] IN_VALUE,
   lp_filter_sampler_if.master  out_if
);

   localparam int SETTLE_W    = clog2(SETTLE_CYCLES + 32'sd1) + 32'sd1;
   localparam int DECIM_W     = clog2(DECIM) + 32'sd1;
   localparam int SETTLE_LAST = (SETTLE_CYCLES > 32'sd0) ? (SETTLE_CYCLES - 32'sd1) : 32'sd0;
   localparam int LEVEL_BITS  = clog2(FIFO_DEPTH) + 32'sd1;

   state_t                state_q, state_d;
   logic [SETTLE_W-1:0]   settle_cnt_q, settle_cnt_d;
   logic [DECIM_W-1:0]    decim_cnt_q, decim_cnt_d;
   logic [DROP_BITS-1:0]  drop_q, drop_d;
   logic                  run_s, tick_s, pop_s, drop_s;
   logic                  fifo_full_s, fifo_empty_s;
   logic [DATA_BITS-1:0]  sample_s, head_s;
   logic [LEVEL_BITS-1:0] level_s;

   // With no settle time the decimator is live from the first cycle after reset.
   assign run_s = (state_q == ST_RUN) || (SETTLE_CYCLES == 32'sd0);

   // FSM next-state, settle/decimation counters and capture tick.
   always_comb begin
      state_d      = state_q;
      settle_cnt_d = settle_cnt_q;
      decim_cnt_d  = decim_cnt_q;
      tick_s       = 1'b0;

      case (state_q)
         ST_SETTLE: begin
            if (SETTLE_CYCLES == 32'sd0) begin
               state_d = ST_RUN;
            end else if (CE) begin
               if (settle_cnt_q == SETTLE_W'(SETTLE_LAST)) begin
                  state_d = ST_RUN;
               end else begin
                  settle_cnt_d = settle_cnt_q + SETTLE_W'(1);
               end
            end else begin
               state_d = ST_SETTLE;
            end
         end
         ST_RUN:  state_d = ST_RUN;
         default: state_d = ST_SETTLE;
      endcase

      if (run_s && CE) begin
         if (decim_cnt_q == DECIM_W'(DECIM - 32'sd1)) begin
            tick_s      = 1'b1;
            decim_cnt_d = {DECIM_W{1'b0}};
         end else begin
            decim_cnt_d = decim_cnt_q + DECIM_W'(1);
         end
      end else begin
         decim_cnt_d = decim_cnt_q;
      end
   end

   // Pops follow the consumer only; CE never stalls the read side.
   assign pop_s  = ~fifo_empty_s & out_if.OUT_READY;
   assign drop_s = tick_s & fifo_full_s & ~pop_s;

   // Saturating drop counter.
   always_comb begin
      drop_d = drop_q;
      if (drop_s && (drop_q != {DROP_BITS{1'b1}})) begin
         drop_d = drop_q + DROP_BITS'(1);
      end else begin
         drop_d = drop_q;
      end
   end

   // FSM, counter and drop state with synchronous reset.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q      <= ST_SETTLE;
         settle_cnt_q <= {SETTLE_W{1'b0}};
         decim_cnt_q  <= {DECIM_W{1'b0}};
         drop_q       <= {DROP_BITS{1'b0}};
      end else begin
         state_q      <= state_d;
         settle_cnt_q <= settle_cnt_d;
         decim_cnt_q  <= decim_cnt_d;
         drop_q       <= drop_d;
      end
   end

`ifdef LP_FILTER_SAMPLER_DELTA_EN
   logic [DATA_BITS-1:0] prev_q, prev_d;

   // Every tick updates the reference value, including ticks whose sample is dropped.
   always_comb begin
      prev_d = prev_q;
      if (tick_s) begin
         prev_d = IN_VALUE;
      end else begin
         prev_d = prev_q;
      end
   end

   // Previous-capture register.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         prev_q <= {DATA_BITS{1'b0}};
      end else begin
         prev_q <= prev_d;
      end
   end

   assign sample_s = IN_VALUE - prev_q;
`else
   assign sample_s = IN_VALUE;
`endif

   sample_fifo #(
      .DATA_BITS  (DATA_BITS),
      .FIFO_DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (CLK),
      .rst       (RESET),
      .push      (tick_s),
      .push_data (sample_s),
      .pop       (pop_s),
      .head_data (head_s),
      .full      (fifo_full_s),
      .empty     (fifo_empty_s),
      .level     (level_s)
   );

   assign out_if.OUT_VALUE  = head_s;
   assign out_if.OUT_VALID  = ~fifo_empty_s;
   assign out_if.FIFO_LEVEL = level_s;
   assign out_if.DROP_COUNT = drop_q;

endmodule
